id_stg: RTL and testbench

Instruction-decode stage of the 8-bit RISC pipeline. It is the consumer of the fetch stage's 24-bit instruction stream. It accepts one instruction per cycle over a valid/ready handshake, decodes it, and reads operands from an internal 8×8-bit register file. The register file has a writeback port with same-cycle bypass. The stage detects load-use hazards, honours downstream stall and flush, and drives a registered ID/EX pipeline register to the execute stage.

---
 rtl/id_stg.sv | 207 ++++++++++++++++++++
 tb/tb_id_stg.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stg.sv
// id_stg: instruction-decode stage of the 8-bit RISC pipeline.
// Accepts one 24-bit instruction per cycle from fetch (valid/ready), decodes it,
// reads operands from an 8x8 register file (r0 = 0, same-cycle writeback bypass),
// inserts a bubble on load-use hazards, honours ex_stall/flush, and drives the
// registered ID/EX pipeline register. A HALT parks the stage until a flush.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   fe_instr/fe_valid/fe_ready  instruction stream from fetch
//   ex_stall, flush             downstream back-pressure and squash
//   wb_en/wb_addr/wb_data       register-file writeback
//   ex_*                        registered ID/EX payload
//   ex_illegal                  sticky illegal-opcode flag
//   halted                      stage is parked after HALT
module id_stg #(
    parameter int unsigned NREG = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] fe_instr,
    input  logic        fe_valid,
    output logic        fe_ready,
    input  logic        ex_stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [7:0]  wb_data,
    output logic        ex_valid,
    output logic [3:0]  ex_op,
    output logic [2:0]  ex_rd,
    output logic [7:0]  ex_a,
    output logic [7:0]  ex_b,
    output logic [7:0]  ex_imm,
    output logic        ex_use_imm,
    output logic        ex_we,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_illegal,
    output logic        halted
);
    localparam int unsigned XLEN = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned OPW  = 4;

    localparam logic [OPW-1:0] OP_ADD  = 4'h1;
    localparam logic [OPW-1:0] OP_SUB  = 4'h2;
    localparam logic [OPW-1:0] OP_AND  = 4'h3;
    localparam logic [OPW-1:0] OP_OR   = 4'h4;
    localparam logic [OPW-1:0] OP_XOR  = 4'h5;
    localparam logic [OPW-1:0] OP_ADDI = 4'h6;
    localparam logic [OPW-1:0] OP_LD   = 4'h7;
    localparam logic [OPW-1:0] OP_ST   = 4'h8;
    localparam logic [OPW-1:0] OP_BEQ  = 4'h9;
    localparam logic [OPW-1:0] OP_JMP  = 4'hA;
    localparam logic [OPW-1:0] OP_HALT = 4'hB;

    typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

    typedef struct packed {
        logic            valid;
        logic [OPW-1:0]  op;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            we;
        logic            mem_rd;
        logic            mem_wr;
        logic            branch;
        logic            jump;
    } idex_t;

    state_t          r_state;
    idex_t           r_ex;
    logic            r_illegal;
    logic [XLEN-1:0] r_rf [NREG];

    logic [OPW-1:0]  w_op;
    logic [AW-1:0]   w_rd;
    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_hz;
    logic            w_ready;
    logic            w_xfer;
    logic            w_is_illegal;
    idex_t           w_dec;
    logic            w_unused_rsvd;

    // Instruction field split; bits [10:8] are reserved and ignored.
    assign w_op          = fe_instr[23:20];
    assign w_rd          = fe_instr[19:17];
    assign w_rs1         = fe_instr[16:14];
    assign w_rs2         = fe_instr[13:11];
    assign w_unused_rsvd = ^fe_instr[10:8];
    assign w_is_illegal  = (w_op >= 4'hC);

    // Which source registers the offered instruction actually reads.
    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ST, OP_BEQ: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OP_ADDI, OP_LD: w_use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // Register-file read with r0 forced to zero and writeback bypass.
    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (w_rs1 != '0)
            w_rs1_data = (wb_en && (wb_addr == w_rs1)) ? wb_data : r_rf[w_rs1];
        if (w_rs2 != '0)
            w_rs2_data = (wb_en && (wb_addr == w_rs2)) ? wb_data : r_rf[w_rs2];
    end

    // Decoded ID/EX payload; NOP, HALT and illegal opcodes carry valid=0.
    always_comb begin
        w_dec         = '0;
        w_dec.valid   = (w_op >= OP_ADD) && (w_op <= OP_JMP);
        w_dec.op      = w_op;
        w_dec.rd      = w_rd;
        w_dec.a       = w_rs1_data;
        w_dec.b       = w_rs2_data;
        w_dec.imm     = fe_instr[7:0];
        w_dec.use_imm = (w_op == OP_ADDI) || (w_op == OP_LD) || (w_op == OP_ST);
        w_dec.we      = (w_op >= OP_ADD) && (w_op <= OP_LD) && (w_rd != '0);
        w_dec.mem_rd  = (w_op == OP_LD);
        w_dec.mem_wr  = (w_op == OP_ST);
        w_dec.branch  = (w_op == OP_BEQ);
        w_dec.jump    = (w_op == OP_JMP);
    end

    // Load-use hazard against the load currently sitting in ID/EX.
    assign w_hz = fe_valid && r_ex.valid && r_ex.mem_rd && (r_ex.rd != '0) &&
                  ((w_use_rs1 && (w_rs1 == r_ex.rd)) || (w_use_rs2 && (w_rs2 == r_ex.rd)));

    assign w_ready  = rst_n && (r_state == S_RUN) && !ex_stall && !w_hz && !flush;
    assign w_xfer   = fe_valid && w_ready;
    assign fe_ready = w_ready;

    // Register file; r0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) r_rf[i] <= '0;
        end else if (wb_en && (wb_addr != '0)) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // FSM, sticky illegal flag and ID/EX register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            r_illegal <= 1'b0;
            r_ex      <= '0;
        end else begin
            case (r_state)
                S_RUN:    if (w_xfer && (w_op == OP_HALT)) r_state <= S_HALTED;
                S_HALTED: if (flush) r_state <= S_RUN;
                default:  r_state <= S_RUN;
            endcase

            if (w_xfer && w_is_illegal) r_illegal <= 1'b1;

            // Flush beats stall; hazard, HALTED and idle all fall to a bubble.
            // Bubbles drop the control flags so a stale load cannot re-trigger a hazard.
            if (flush || (!ex_stall && !w_xfer)) begin
                r_ex.valid   <= 1'b0;
                r_ex.use_imm <= 1'b0;
                r_ex.we      <= 1'b0;
                r_ex.mem_rd  <= 1'b0;
                r_ex.mem_wr  <= 1'b0;
                r_ex.branch  <= 1'b0;
                r_ex.jump    <= 1'b0;
            end else if (!ex_stall) begin
                r_ex <= w_dec;
            end
        end
    end

    assign ex_valid   = r_ex.valid;
    assign ex_op      = r_ex.op;
    assign ex_rd      = r_ex.rd;
    assign ex_a       = r_ex.a;
    assign ex_b       = r_ex.b;
    assign ex_imm     = r_ex.imm;
    assign ex_use_imm = r_ex.use_imm;
    assign ex_we      = r_ex.we;
    assign ex_mem_rd  = r_ex.mem_rd;
    assign ex_mem_wr  = r_ex.mem_wr;
    assign ex_branch  = r_ex.branch;
    assign ex_jump    = r_ex.jump;
    assign ex_illegal = r_illegal;
    assign halted     = (r_state == S_HALTED);

endmodule

// File: tb/tb_id_stg.sv
// tb_id_stg: directed scenarios plus randomized traffic for id_stg, checked
// against an instruction-level reference model of the decode stage.
module tb_id_stg;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] fe_instr;
    logic        fe_valid;
    logic        fe_ready;
    logic        ex_stall;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [2:0]  ex_rd;
    logic [7:0]  ex_a;
    logic [7:0]  ex_b;
    logic [7:0]  ex_imm;
    logic        ex_use_imm;
    logic        ex_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_illegal;
    logic        halted;

    always #5 clk = ~clk;

    id_stg dut (
        .clk(clk), .rst_n(rst_n),
        .fe_instr(fe_instr), .fe_valid(fe_valid), .fe_ready(fe_ready),
        .ex_stall(ex_stall), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_use_imm(ex_use_imm), .ex_we(ex_we),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_illegal(ex_illegal), .halted(halted)
    );

    typedef struct packed {
        logic       v;
        logic [3:0] op;
        logic [2:0] rd;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] imm;
        logic       ui;
        logic       we;
        logic       mr;
        logic       mw;
        logic       br;
        logic       jp;
    } ex_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: ID/EX contents, HALT flag, sticky illegal, register file.
    ex_t        m_ex, n_ex;
    bit         m_halt, n_halt, m_ill, n_ill;
    logic [7:0] m_rf [8];
    logic [7:0] n_rf [8];
    bit         obs_ready, exp_ready;

    // Observed payload; fields beyond valid only matter when valid is set.
    logic [37:0] obs_full, obs_ex;
    assign obs_full = {ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_imm,
                       ex_use_imm, ex_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump};
    assign obs_ex   = ex_valid ? obs_full : 38'b0;

    function automatic logic [37:0] pack_ex(input ex_t e);
        if (!e.v) return 38'b0;
        return {e.v, e.op, e.rd, e.a, e.b, e.imm, e.ui, e.we, e.mr, e.mw, e.br, e.jp};
    endfunction

    function automatic logic [7:0] rd_reg(input logic [2:0] r);
        if (r == 3'd0) return 8'h00;
        if (wb_en && wb_addr == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic ex_t decode(input logic [23:0] ins);
        ex_t e;
        logic [3:0] op = ins[23:20];
        logic [2:0] rd = ins[19:17];
        e.v   = (op >= 4'd1) && (op <= 4'd10);
        e.op  = op;
        e.rd  = rd;
        e.a   = rd_reg(ins[16:14]);
        e.b   = rd_reg(ins[13:11]);
        e.imm = ins[7:0];
        e.ui  = (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
        e.we  = (op >= 4'd1) && (op <= 4'd7) && (rd != 3'd0);
        e.mr  = (op == 4'd7);
        e.mw  = (op == 4'd8);
        e.br  = (op == 4'd9);
        e.jp  = (op == 4'd10);
        return e;
    endfunction

    function automatic bit m_hz();
        logic [3:0] op = fe_instr[23:20];
        bit u1 = (op >= 4'd1) && (op <= 4'd9);
        bit u2 = ((op >= 4'd1) && (op <= 4'd5)) || (op == 4'd8) || (op == 4'd9);
        bit hit = (u1 && fe_instr[16:14] == m_ex.rd) || (u2 && fe_instr[13:11] == m_ex.rd);
        return fe_valid && m_ex.v && m_ex.mr && (m_ex.rd != 3'd0) && hit;
    endfunction

    function automatic bit m_ready();
        return rst_n && !m_halt && !ex_stall && !m_hz() && !flush;
    endfunction

    task automatic m_reset();
        m_ex = '0; m_halt = 0; m_ill = 0;
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    endtask

    task automatic idle_inputs();
        fe_valid = 0; fe_instr = 24'h0; ex_stall = 0; flush = 0;
        wb_en = 0; wb_addr = 3'd0; wb_data = 8'h00;
    endtask

    // One clock: sample fe_ready mid-cycle, advance model and DUT, settle past the edge.
    task automatic cycle();
        bit xfer;
        logic [3:0] op;
        @(negedge clk);
        obs_ready = fe_ready;
        exp_ready = m_ready();
        op   = fe_instr[23:20];
        xfer = fe_valid && exp_ready;
        n_rf = m_rf;
        if (!rst_n) begin
            n_ex = '0; n_halt = 0; n_ill = 0;
            for (int i = 0; i < 8; i++) n_rf[i] = 8'h00;
        end else begin
            if (flush)         begin n_ex = m_ex; n_ex.v = 1'b0; end
            else if (ex_stall) n_ex = m_ex;
            else if (xfer)     n_ex = decode(fe_instr);
            else               begin n_ex = m_ex; n_ex.v = 1'b0; end
            n_halt = m_halt ? !flush : (xfer && op == 4'hB);
            n_ill  = m_ill || (xfer && op >= 4'hC);
            if (wb_en && wb_addr != 3'd0) n_rf[wb_addr] = wb_data;
        end
        @(posedge clk);
        m_ex = n_ex; m_halt = n_halt; m_ill = n_ill; m_rf = n_rf;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        flush = 1'b1;
        cycle();
        idle_inputs();
        wb_en = 1; wb_addr = 3'd3; wb_data = 8'hA5;
        fe_valid = 1; fe_instr = 24'h12C000;           // ADD r1,r3,r0 with bypassed r3
        cycle();
        n_tests++;
        if (ex_valid !== 1'b1 || ex_a !== 8'hA5) begin
            n_fail++; $display("FAIL reset_pre_issue: valid=%b a=%h, want 1 a5", ex_valid, ex_a);
        end
        idle_inputs();
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        n_tests++;
        if ({obs_full, halted, ex_illegal} !== 40'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %h halted=%b ill=%b, want all 0", obs_full, halted, ex_illegal);
        end
        n_tests++;
        if (fe_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", fe_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        fe_valid = 1; fe_instr = 24'h12C000;
        cycle();
        n_tests++;
        if (obs_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b want 1", obs_ready);
        end
        n_tests++;
        if (ex_valid !== 1'b1 || ex_a !== 8'h00 || ex_rd !== 3'd1) begin
            n_fail++; $display("FAIL reset_rf_clear: valid=%b a=%h rd=%0d, want 1 00 1", ex_valid, ex_a, ex_rd);
        end
    endtask

    task automatic test_wb_bypass();
        idle_inputs();
        wb_en = 1; wb_addr = 3'd3; wb_data = 8'h5A;
        cycle();
        idle_inputs();
        fe_valid = 1; fe_instr = 24'h12C000;           // ADD r1,r3,r0
        cycle();
        n_tests++;
        if ({ex_valid, ex_a, ex_b, ex_we, ex_rd} !== {1'b1, 8'h5A, 8'h00, 1'b1, 3'd1}) begin
            n_fail++; $display("FAIL rf_read: v=%b a=%h b=%h we=%b rd=%0d, want 1 5a 00 1 1", ex_valid, ex_a, ex_b, ex_we, ex_rd);
        end
        wb_en = 1; wb_addr = 3'd2; wb_data = 8'h11;
        fe_instr = 24'h129000;                         // ADD r1,r2,r2 with same-cycle writeback
        cycle();
        n_tests++;
        if ({ex_valid, ex_a, ex_b} !== {1'b1, 8'h11, 8'h11}) begin
            n_fail++; $display("FAIL bypass: v=%b a=%h b=%h, want 1 11 11", ex_valid, ex_a, ex_b);
        end
        wb_en = 1; wb_addr = 3'd0; wb_data = 8'hFF;
        fe_instr = 24'h120000;                         // ADD r1,r0,r0 while writing r0
        cycle();
        wb_en = 0;
        cycle();
        n_tests++;
        if ({ex_valid, ex_a, ex_b} !== {1'b1, 8'h00, 8'h00}) begin
            n_fail++; $display("FAIL r0_zero: v=%b a=%h b=%h, want 1 00 00", ex_valid, ex_a, ex_b);
        end
        n_tests++;
        if (obs_ex !== pack_ex(m_ex)) begin
            n_fail++; $display("FAIL wb_model: got %h want %h", obs_ex, pack_ex(m_ex));
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        fe_valid = 1; fe_instr = 24'h789008;           // LD r4,[r2+8]
        cycle();
        n_tests++;
        if ({ex_valid, ex_mem_rd, ex_rd, ex_use_imm, ex_imm} !== {1'b1, 1'b1, 3'd4, 1'b1, 8'h08}) begin
            n_fail++; $display("FAIL ld_issue: v=%b mr=%b rd=%0d ui=%b imm=%h", ex_valid, ex_mem_rd, ex_rd, ex_use_imm, ex_imm);
        end
        fe_instr = 24'h1B0000;                         // ADD r5,r4,r0 depends on the load
        cycle();
        n_tests++;
        if (obs_ready !== 1'b0 || ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL load_use_bubble: ready=%b valid=%b, want 0 0", obs_ready, ex_valid);
        end
        cycle();
        n_tests++;
        if (obs_ready !== 1'b1 || ex_valid !== 1'b1 || ex_rd !== 3'd5) begin
            n_fail++; $display("FAIL load_use_issue: ready=%b valid=%b rd=%0d, want 1 1 5", obs_ready, ex_valid, ex_rd);
        end
    endtask

    task automatic test_stall_flush();
        logic [37:0] snap;
        idle_inputs();
        fe_valid = 1; fe_instr = 24'h12C000;
        cycle();
        snap = pack_ex(m_ex);
        ex_stall = 1; fe_instr = 24'h129000;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_tests++;
            if (obs_ready !== 1'b0 || obs_full !== snap) begin
                n_fail++; $display("FAIL stall_hold[%0d]: ready=%b ex=%h, want 0 %h", k, obs_ready, obs_full, snap);
            end
        end
        flush = 1;
        cycle();
        n_tests++;
        if (ex_valid !== 1'b0 || obs_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_over_stall: valid=%b ready=%b, want 0 0", ex_valid, obs_ready);
        end
        flush = 0; ex_stall = 0;
        cycle();
        n_tests++;
        if (ex_valid !== 1'b1 || obs_ex !== pack_ex(m_ex)) begin
            n_fail++; $display("FAIL after_flush: got %h want %h", obs_ex, pack_ex(m_ex));
        end
    endtask

    task automatic test_halt();
        idle_inputs();
        fe_valid = 1; fe_instr = 24'hB00000;
        cycle();
        n_tests++;
        if (halted !== 1'b1 || ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_enter: halted=%b valid=%b, want 1 0", halted, ex_valid);
        end
        fe_instr = 24'h12C000;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_tests++;
            if (obs_ready !== 1'b0 || ex_valid !== 1'b0 || halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_park[%0d]: ready=%b valid=%b halted=%b, want 0 0 1", k, obs_ready, ex_valid, halted);
            end
        end
        flush = 1;
        cycle();
        n_tests++;
        if (obs_ready !== 1'b0 || halted !== 1'b0 || ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_flush: ready=%b halted=%b valid=%b, want 0 0 0", obs_ready, halted, ex_valid);
        end
        flush = 0;
        cycle();
        n_tests++;
        if (obs_ready !== 1'b1 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL halt_resume: ready=%b valid=%b, want 1 1", obs_ready, ex_valid);
        end
    endtask

    task automatic test_illegal();
        idle_inputs();
        fe_valid = 1; fe_instr = 24'hF00000;
        cycle();
        n_tests++;
        if (ex_valid !== 1'b0 || ex_illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_set: valid=%b ill=%b, want 0 1", ex_valid, ex_illegal);
        end
        fe_instr = 24'h12C000;
        cycle();
        cycle();
        n_tests++;
        if (ex_valid !== 1'b1 || ex_illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_sticky: valid=%b ill=%b, want 1 1", ex_valid, ex_illegal);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int k = 0; k < 600; k++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = 4'd7;
            fe_instr = {op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                        3'($urandom_range(0, 7)), 3'($urandom), 8'($urandom)};
            fe_valid = ($urandom_range(0, 9) < 8);
            ex_stall = ($urandom_range(0, 99) < 15);
            flush    = ($urandom_range(0, 99) < 8);
            wb_en    = $urandom_range(0, 1);
            wb_addr  = 3'($urandom_range(0, 7));
            wb_data  = 8'($urandom);
            cycle();
            n_tests++;
            if (obs_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", k, obs_ready, exp_ready);
            end
            n_tests++;
            if (obs_ex !== pack_ex(m_ex)) begin
                n_fail++; $display("FAIL rand_ex[%0d]: got %h want %h", k, obs_ex, pack_ex(m_ex));
            end
            n_tests++;
            if (halted !== m_halt || ex_illegal !== m_ill) begin
                n_fail++; $display("FAIL rand_flags[%0d]: halted=%b ill=%b want %b %b", k, halted, ex_illegal, m_halt, m_ill);
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_wb_bypass();
        test_load_use();
        test_stall_flush();
        test_halt();
        test_illegal();
        test_random();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
